// File: rtl/rv_fetch_pkg.sv
// rv_fetch_pkg: shared fetch constants, response record and width helper
package rv_fetch_pkg;
  localparam int FETCH_AW = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [FETCH_AW-1:0] addr;
    logic [31:0] instr;
    logic fault;
  } fetch_rsp_t;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: circular-buffer FIFO with same-cycle push/pop and synchronous flush
module sync_fifo
  import rv_fetch_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = DEPTH > 1 ? clog2(DEPTH) : 1;
  localparam int CW = clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic wr, rd;
  assign full = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  assign rd = pop && !empty;
  assign wr = push && (!full || rd);
  assign rdata = mem[rp];
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
  endfunction
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= inc(wp);
      if (rd) rp <= inc(rp);
      cnt <= cnt + CW'(wr) - CW'(rd);
    end
    if (wr) mem[wp] <= wdata;
  end
endmodule

// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder: credit-limited instruction RAM fetch responder with fixed read latency
module imem_fetch_responder
  import rv_fetch_pkg::*;
#(
  parameter int          ADDR_WIDTH  = FETCH_AW,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [31:0] NOP_INSTR   = rv_fetch_pkg::NOP_INSTR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_flush,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_instr,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic                  rsp_fault,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [31:0]           prog_wdata
);
  localparam int IW = clog2(DEPTH_WORDS);
  localparam int CW = clog2(FIFO_DEPTH) + 1;
  logic [31:0] mem [DEPTH_WORDS];
  logic [CW-1:0] outstanding;
  logic accept, pop, req_fault, push_v, f_empty, fifo_full_unused;
  fetch_rsp_t s_d, push_d, head;
  assign req_fault = |req_addr[1:0] || (req_addr >> (IW + 2)) != '0;
  assign req_ready = !rst && !req_flush && outstanding < CW'(FIFO_DEPTH);
  assign accept = req_valid && req_ready;
  assign pop = rsp_valid && rsp_ready;
  // Stage 0 is the accept cycle itself: the RAM read is combinational here, so read-first falls out
  assign s_d = '{addr: req_addr, instr: req_fault ? NOP_INSTR : mem[req_addr[IW+1:2]], fault: req_fault};
  always_ff @(posedge clk) begin
    if (prog_we && (prog_addr >> (IW + 2)) == '0) mem[prog_addr[IW+1:2]] <= prog_wdata;
  end
  always_ff @(posedge clk) begin
    outstanding <= (rst || req_flush) ? '0 : outstanding + CW'(accept) - CW'(pop);
  end
  if (LATENCY == 1) begin : g_direct
    assign push_v = accept;
    assign push_d = s_d;
  end else begin : g_pipe
    logic [LATENCY-2:0] v;
    fetch_rsp_t d [LATENCY-1];
    always_ff @(posedge clk) begin
      v <= (rst || req_flush) ? '0 : (LATENCY-1)'({v, accept});
      d[0] <= s_d;
      for (int i = 1; i < LATENCY - 1; i++) d[i] <= d[i-1];
    end
    assign push_v = v[LATENCY-2];
    assign push_d = d[LATENCY-2];
  end
  sync_fifo #(.WIDTH($bits(fetch_rsp_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(req_flush),
    .push(push_v),
    .wdata(push_d),
    .pop(pop),
    .rdata(head),
    .full(fifo_full_unused),
    .empty(f_empty)
  );
  assign rsp_valid = !f_empty;
  assign rsp_instr = f_empty ? NOP_INSTR : head.instr;
  assign rsp_addr = f_empty ? '0 : head.addr;
  assign rsp_fault = !f_empty && head.fault;
endmodule

// File: doc/imem_fetch_responder.md
Name: imem_fetch_responder

Overview:
Instruction-memory responder on the far end of the fetch interface. It accepts PC fetch requests from the IF stage over a valid/ready handshake and reads the addressed word from an internal word-addressed instruction RAM. It returns the instruction after a fixed, parameterised pipeline latency through a small response FIFO. It also supports redirect flushes on jump/branch and a program-load write port.

Parameters:
ADDR_WIDTH, 32, width of request/program byte addresses
DEPTH_WORDS, 1024, instruction RAM depth in 32-bit words (power of two)
LATENCY, 2, read pipeline stages from accept to FIFO push (legal 1..4)
FIFO_DEPTH, 4, response FIFO entries; also the max outstanding requests (must be >= LATENCY+1)
NOP_INSTR, 32'h0000_0013, word returned on a faulting fetch

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  1  fetch request valid
req_ready  out  1  responder can accept a request
req_addr  in  ADDR_WIDTH  fetch byte address (PC)
req_flush  in  1  redirect: discard all in-flight and buffered responses
rsp_valid  out  1  response valid
rsp_ready  in  1  IF stage accepts the response
rsp_instr  out  32  fetched instruction, or NOP_INSTR on fault
rsp_addr  out  ADDR_WIDTH  address of the returned instruction
rsp_fault  out  1  misaligned or out-of-range fetch
prog_we  in  1  program-load write enable
prog_addr  in  ADDR_WIDTH  program-load byte address (word index = prog_addr[.. :2])
prog_wdata  in  32  program-load data

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: rsp_valid=0, rsp_fault=0, rsp_instr=NOP_INSTR, rsp_addr=0, pipeline valids=0, FIFO empty, outstanding count=0. req_ready=0 while rst is high. RAM contents are not reset.
- Accept: a request is accepted when req_valid && req_ready. req_ready = !rst && !req_flush && (outstanding < FIFO_DEPTH).
- Outstanding counter:
  - +1 on accept, -1 on response handshake (rsp_valid && rsp_ready); both in the same cycle leaves it unchanged.
  - Cleared to 0 on req_flush.
  - Width is clog2(FIFO_DEPTH)+1.
- Read pipeline: LATENCY-stage shift register carrying {valid, addr, instr, fault}. RAM is read in the accept cycle. The entry exits the last stage and pushes into the FIFO. The credit scheme guarantees a free FIFO slot, so push never stalls and the pipeline never backs up.
- Latency: request accepted at cycle N with an empty FIFO gives rsp_valid=1 at N+LATENCY. With rsp_ready held high, throughput is one instruction per cycle.
- Response: rsp_* are driven from the FIFO head and held stable while rsp_valid && !rsp_ready. Push and pop in the same cycle are allowed when the FIFO is full or empty (bypass not required; empty+push shows data next cycle).
- Faults:
  - req_addr[1:0] != 0, or word index >= DEPTH_WORDS: the request is still accepted, with rsp_fault=1, rsp_instr=NOP_INSTR, and rsp_addr = the faulting address.
  - Faults do not stop the stream.
- Flush: req_flush clears all pipeline valids, empties the FIFO, and zeroes the counter in that cycle. rsp_valid is 0 the next cycle. No request is accepted in the flush cycle. A flush concurrent with a response handshake drops that response regardless.
- Program write: prog_we writes prog_wdata at word index prog_addr[...:2]. Out-of-range writes are ignored. A same-cycle fetch of the same word returns the old data (read-first).
- Address arithmetic: word index = req_addr[clog2(DEPTH_WORDS)+1:2]. Range check uses the full address. No wrap-around aliasing.

Decomposition:
- Shared package rv_fetch_pkg:
  - NOP_INSTR constant
  - fetch response struct {addr, instr, fault}
  - clog2 helper
- One sub-module: sync_fifo (parameter WIDTH, DEPTH; push/pop/full/empty/flush).
- RAM array, pipeline, and credit counter stay in the top module.

Test Plan:
- Reset then single fetch: LATENCY=2, load 0x00500093 at byte addr 0x0, req_addr=0x0 at cycle N -> rsp_valid at N+2, rsp_instr=0x00500093, rsp_addr=0x0, rsp_fault=0.
- Streaming: fetch 0x0,0x4,...,0x3C back-to-back with rsp_ready=1 -> 16 responses on consecutive cycles, in order, matching the loaded words.
- Backpressure: rsp_ready=0, issue requests -> req_ready drops after exactly FIFO_DEPTH=4 accepts. Release rsp_ready -> 4 ordered responses, then req_ready=1.
- Faults: req_addr=0x6 -> rsp_fault=1, rsp_instr=0x00000013. req_addr=0x1000 (DEPTH_WORDS=1024) -> rsp_fault=1. The next request 0x8 returns normally.
- Flush mid-stream: 3 outstanding, assert req_flush for 1 cycle -> rsp_valid=0 next cycle, no stale responses. A new fetch of 0x40 returns only the 0x40 word.
- Read-first and reset mid-operation: write 0xDEADBEEF to 0x10 while fetching 0x10 -> old word returned, a re-fetch returns 0xDEADBEEF. Assert rst with 2 outstanding -> rsp_valid=0 and req_ready=0 during reset, and no responses after release.
